// File: rtl/grf_multiport.sv
// Purpose : parametrised CPU register file with NR bypassed read ports, one writeback port,
//           per-register pending scoreboard and a commit counter.
// Latency : reads 0 cycles (write-first bypass); writes visible in storage the cycle after commit.
// Backpressure: none, the block accepts a write and an issue every cycle.
//
// Ports:
//   clk, clr_n           clock; synchronous active-low clear of mem, pending, wr_cnt
//   pc                   PC of the writeback instruction, used only by the trace
//   we, a3, wd           writeback port (a3 == 0 is ignored)
//   ra / rd / rd_pend    NR read ports packed k*AW / k*DW / bit k
//   iss_v, iss_a         decode issue, marks iss_a as having an outstanding producer
//   wr_cnt               count of committed writes since reset, wraps at 2^32
//
// Optional build macro GRF_TRACE_EN: adds a cycle counter and prints one line per commit.
module grf_multiport #(
    parameter int          DW      = 32,
    parameter int          AW      = 5,
    parameter int          NR      = 2,
    parameter logic [31:0] PC_BASE = 32'h0000_3000
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [31:0]      pc,
    input  logic             we,
    input  logic [AW-1:0]    a3,
    input  logic [DW-1:0]    wd,
    input  logic [NR*AW-1:0] ra,
    output logic [NR*DW-1:0] rd,
    output logic [NR-1:0]    rd_pend,
    input  logic             iss_v,
    input  logic [AW-1:0]    iss_a,
    output logic [31:0]      wr_cnt
);

    localparam int DEPTH = 1 << AW;

    // Power-up values are zero so reads before the first clear are well defined.
    logic [DW-1:0]    mem_q [DEPTH] = '{default: '0};
    logic [DW-1:0]    mem_d [DEPTH];
    logic [DEPTH-1:0] pend_q = '0;
    logic [DEPTH-1:0] pend_d;
    logic [31:0]      wr_cnt_q = '0;
    logic [31:0]      wr_cnt_d;

    logic commit;
    logic issue;

    // Register 0 is hard-wired: writes and issues to it are dropped here.
    assign commit = we && (a3 != '0);
    assign issue  = iss_v && (iss_a != '0);

    always_comb begin
        mem_d    = mem_q;
        pend_d   = pend_q;
        wr_cnt_d = wr_cnt_q;
        if (commit) begin
            mem_d[a3]    = wd;
            pend_d[a3]   = 1'b0;
            wr_cnt_d     = wr_cnt_q + 32'd1;
        end
        // Applied after the commit clear: a new producer issued in the same
        // cycle as the old one retires keeps the register pending.
        if (issue) begin
            pend_d[iss_a] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            mem_q    <= '{default: '0};
            pend_q   <= '0;
            wr_cnt_q <= '0;
        end else begin
            mem_q    <= mem_d;
            pend_q   <= pend_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign wr_cnt = wr_cnt_q;

    // Read ports: a same-cycle commit to the read address forwards wd and
    // also hides the pending bit, so data and hazard stay consistent.
    for (genvar k = 0; k < NR; k++) begin : g_rd
        logic [AW-1:0] ra_k;
        logic          hit;
        assign ra_k = ra[k*AW +: AW];
        assign hit  = we && (a3 == ra_k);
        assign rd[k*DW +: DW] = (ra_k == '0) ? '0 : (hit ? wd : mem_q[ra_k]);
        assign rd_pend[k]     = (ra_k != '0) && pend_q[ra_k] && !hit;
    end

`ifdef GRF_TRACE_EN
    logic [31:0] cyc_q = '0;
    logic [31:0] cyc_d;
    logic        unused_pc;

    assign cyc_d     = cyc_q + 32'd1;
    assign unused_pc = ^pc[31:12];

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            if (commit) begin
                $display("%d@%h: $%d <= %h", cyc_q, PC_BASE | {20'h0, pc[11:0]}, a3, wd);
            end
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_grf_multiport.sv
module tb_grf_multiport;

    logic        clk = 1'b0;
    logic        clr_n = 1'b1;
    logic [31:0] pc = '0;
    logic        we = 1'b0;
    logic [4:0]  a3 = '0;
    logic [31:0] wd = '0;
    logic [9:0]  ra = '0;
    logic [63:0] rd;
    logic [1:0]  rd_pend;
    logic        iss_v = 1'b0;
    logic [4:0]  iss_a = '0;
    logic [31:0] wr_cnt;

    // Second instance: four ports, 16 registers.
    logic         we4 = 1'b0;
    logic [3:0]   a34 = '0;
    logic [31:0]  wd4 = '0;
    logic [15:0]  ra4 = '0;
    logic [127:0] rd4;
    logic [3:0]   rd_pend4;
    logic [31:0]  wr_cnt4;

    always #5 clk = ~clk;

    grf_multiport u_dut (
        .clk(clk), .clr_n(clr_n), .pc(pc), .we(we), .a3(a3), .wd(wd),
        .ra(ra), .rd(rd), .rd_pend(rd_pend), .iss_v(iss_v), .iss_a(iss_a),
        .wr_cnt(wr_cnt)
    );

    grf_multiport #(.DW(32), .AW(4), .NR(4)) u_dut4 (
        .clk(clk), .clr_n(clr_n), .pc(32'h0), .we(we4), .a3(a34), .wd(wd4),
        .ra(ra4), .rd(rd4), .rd_pend(rd_pend4), .iss_v(1'b0), .iss_a(4'h0),
        .wr_cnt(wr_cnt4)
    );

    typedef struct {
        logic [1:0][31:0] rd;
        logic [1:0]       pend;
        logic [31:0]      cnt;
        bit               chk_comb;
    } exp_t;

    typedef struct {
        logic [3:0][31:0] rd;
        logic [31:0]      cnt;
    } exp4_t;

    exp_t  q[$];
    exp4_t q4[$];

    int checks = 0;
    int errors = 0;

    // Reference model: architectural state as plain arrays.
    logic [31:0] m_mem [32];
    bit          m_pend[32];
    logic [31:0] m_cnt;

    function automatic logic [31:0] model_read(input logic [4:0] addr, input bit w,
                                               input logic [4:0] wa, input logic [31:0] d);
        if (addr == 0) return 32'h0;
        if (w && wa == addr) return d;
        return m_mem[addr];
    endfunction

    function automatic bit model_pend(input logic [4:0] addr, input bit w, input logic [4:0] wa);
        return (addr != 0) && m_pend[addr] && !(w && wa == addr);
    endfunction

    // One clock of stimulus: drive, record expected outputs, then advance the model.
    task automatic cyc(input bit c, input bit w, input logic [4:0] a, input logic [31:0] d,
                       input bit iv, input logic [4:0] ia,
                       input logic [4:0] r0, input logic [4:0] r1, input bit chk);
        exp_t e;
        logic [4:0] r [2];
        @(posedge clk);
        #1;
        clr_n = c; we = w; a3 = a; wd = d; iss_v = iv; iss_a = ia;
        ra = {r1, r0}; pc = $urandom;
        r[0] = r0; r[1] = r1;
        for (int k = 0; k < 2; k++) begin
            e.rd[k]   = model_read(r[k], w, a, d);
            e.pend[k] = model_pend(r[k], w, a);
        end
        e.cnt      = m_cnt;
        e.chk_comb = chk;
        q.push_back(e);
        if (!c) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  = '0;
                m_pend[i] = 1'b0;
            end
            m_cnt = '0;
        end else begin
            if (w && a != 0) begin
                m_mem[a]  = d;
                m_pend[a] = 1'b0;
                m_cnt     = m_cnt + 1;
            end
            if (iv && ia != 0) m_pend[ia] = 1'b1;
        end
    endtask

    task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
        cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, r0, r1, 1'b1);
    endtask

    // Monitor: outputs are combinational, so every cycle presents a result.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.chk_comb) begin
                for (int k = 0; k < 2; k++) begin
                    checks++;
                    if (rd[k*32 +: 32] !== e.rd[k]) begin
                        errors++;
                        $display("FAIL rd[%0d] ra=%0d got %h exp %h @%0t", k, ra[k*5 +: 5],
                                 rd[k*32 +: 32], e.rd[k], $time);
                    end
                    checks++;
                    if (rd_pend[k] !== e.pend[k]) begin
                        errors++;
                        $display("FAIL rd_pend[%0d] ra=%0d got %b exp %b @%0t", k, ra[k*5 +: 5],
                                 rd_pend[k], e.pend[k], $time);
                    end
                end
            end
            checks++;
            if (wr_cnt !== e.cnt) begin
                errors++;
                $display("FAIL wr_cnt got %0d exp %0d @%0t", wr_cnt, e.cnt, $time);
            end
        end
        if (q4.size() > 0) begin
            exp4_t e4;
            e4 = q4.pop_front();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (rd4[k*32 +: 32] !== e4.rd[k]) begin
                    errors++;
                    $display("FAIL rd4[%0d] got %h exp %h", k, rd4[k*32 +: 32], e4.rd[k]);
                end
            end
            checks++;
            if (wr_cnt4 !== e4.cnt) begin
                errors++;
                $display("FAIL wr_cnt4 got %0d exp %0d", wr_cnt4, e4.cnt);
            end
        end
    end

    initial begin
        exp4_t e4;
        bit c, w, iv;
        logic [4:0] a, ia, r0, r1;

        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_cnt = '0;

        // Power-up state before any clear.
        idle(5'd5, 5'd3);
        // Write 5 <- DEAD, then clear with a write and issue that must be ignored.
        cyc(1'b1, 1'b1, 5'd5, 32'hDEAD, 1'b0, 5'd0, 5'd5, 5'd0, 1'b1);
        cyc(1'b0, 1'b1, 5'd6, 32'hBEEF, 1'b1, 5'd6, 5'd5, 5'd6, 1'b0);
        idle(5'd5, 5'd6);
        // Write/read with bypass, then from storage.
        cyc(1'b1, 1'b1, 5'd3, 32'h1234, 1'b0, 5'd0, 5'd3, 5'd3, 1'b1);
        idle(5'd3, 5'd0);
        // Writes to register 0 are dropped.
        cyc(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1);
        idle(5'd0, 5'd3);
        // Scoreboard set by issue, cleared by commit in the commit cycle.
        cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd7, 1'b1);
        idle(5'd7, 5'd3);
        cyc(1'b1, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd3, 1'b1);
        idle(5'd7, 5'd0);
        // Same-cycle issue and commit: data lands, pending stays set.
        cyc(1'b1, 1'b1, 5'd9, 32'h55, 1'b1, 5'd9, 5'd9, 5'd9, 1'b1);
        idle(5'd9, 5'd7);

        // Four-port instance: writes 1 <- A, 2 <- B, then read 1,1,2,0.
        idle(5'd0, 5'd0);
        we4 = 1'b1; a34 = 4'd1; wd4 = 32'hA;
        idle(5'd0, 5'd0);
        a34 = 4'd2; wd4 = 32'hB;
        idle(5'd0, 5'd0);
        we4 = 1'b0; ra4 = {4'd0, 4'd2, 4'd1, 4'd1};
        e4.rd[0] = 32'hA; e4.rd[1] = 32'hA; e4.rd[2] = 32'hB; e4.rd[3] = 32'h0;
        e4.cnt = 32'd2;
        q4.push_back(e4);
        idle(5'd0, 5'd0);

        // Randomised traffic over a small address window to force collisions.
        for (int n = 0; n < 2000; n++) begin
            c  = ($urandom_range(0, 49) != 0);
            w  = c && ($urandom_range(0, 1) == 1);
            a  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            ia = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            iv = ($urandom_range(0, 2) == 0);
            r0 = ($urandom_range(0, 1) == 0) ? a : 5'($urandom_range(0, 7));
            r1 = ($urandom_range(0, 2) == 0) ? r0 : 5'($urandom_range(0, 7));
            cyc(c, w, a, $urandom, iv, ia, r0, r1, 1'b1);
        end

        for (int t = 0; t < 10 && (q.size() > 0 || q4.size() > 0); t++) @(posedge clk);
        if (q.size() > 0 || q4.size() > 0) begin
            errors++;
            $display("FAIL drain %0d entries left, exp 0", q.size() + q4.size());
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
